// File: rtl/gate_seq_pkg.sv
// Shared types, vector counts and golden cell functions for the gate vector sequencer.
package gate_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } seq_state_t;

    typedef enum logic {
        GATE_NOR2  = 1'b0,
        GATE_OAI21 = 1'b1
    } gate_sel_t;

    localparam int NVEC_NOR2  = 4;
    localparam int NVEC_OAI21 = 8;

    // Expected cell output for vector {c,b,a}; NOR2 ignores c.
    function automatic logic golden(input gate_sel_t sel, input logic [2:0] vec);
        logic a;
        logic b;
        logic c;
        logic res;
        a = vec[0];
        b = vec[1];
        c = vec[2];
        if (sel == GATE_NOR2) begin
            res = ~(a | b);
        end else begin
            res = ~((a | b) & c);
        end
        return res;
    endfunction

endpackage

// File: rtl/gate_vector_sequencer_settle_timer.sv
// Settle window timer: loads on DRIVE, counts down while enabled, flags zero.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count_en,
    output logic zero
);

    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    // The zero test happens in the last SETTLE cycle, so one less than the window is loaded.
    localparam logic [TW-1:0] LOAD_VAL = TW'(SETTLE_CYCLES - 1);

    logic [TW-1:0] cnt;

    // Down-counter; holds at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (count_en && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Exhaustive stimulus/check controller for NOR2 and OAI21 gate cells.
// Optional macro GVS_FIRST_FAIL_LOG_EN adds first_fail_vld/first_fail_vec outputs
// capturing the first mismatching vector of a run.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; results of last run held
//  DRIVE  | present current vector on dut_in, load settle timer
//  SETTLE | hold dut_in while the cell output settles
//  CHECK  | compare dut_out with golden, advance or finish
//  DONE   | one-cycle done pulse, publish pass, park dut_in at 0
module gate_vector_sequencer
    import gate_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             gate_sel,
    output logic [2:0]       dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef GVS_FIRST_FAIL_LOG_EN
    ,
    output logic             first_fail_vld,
    output logic [2:0]       first_fail_vec
`endif
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("gate_vector_sequencer: SETTLE_CYCLES must be in 1..255");
    end
    if (ERR_W < 1) begin : g_bad_err_w
        $error("gate_vector_sequencer: ERR_W must be at least 1");
    end

    seq_state_t       state;
    seq_state_t       state_nxt;
    gate_sel_t        gate_q;
    logic [2:0]       vec;
    logic [2:0]       last_vec;
    logic             accept_start;
    logic             drive_vec;
    logic             timer_en;
    logic             timer_zero;
    logic             check_vec;
    logic             cancel;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    assign last_vec = (gate_q == GATE_OAI21) ? 3'(NVEC_OAI21 - 1) : 3'(NVEC_NOR2 - 1);
    assign mismatch = (dut_out != golden(gate_q, dut_in));
    assign err_next = (mismatch && (err_count != {ERR_W{1'b1}})) ? err_count + ERR_W'(1)
                                                                  : err_count;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (drive_vec),
        .count_en(timer_en),
        .zero    (timer_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes; abort overrides everything else.
    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        drive_vec    = 1'b0;
        timer_en     = 1'b0;
        check_vec    = 1'b0;
        cancel       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (state)
            IDLE: begin
                if (!abort && start) begin
                    accept_start = 1'b1;
                    state_nxt    = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (abort) begin
                    cancel    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    drive_vec = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    cancel    = 1'b1;
                    state_nxt = IDLE;
                end else if (timer_zero) begin
                    state_nxt = CHECK;
                end else begin
                    timer_en = 1'b1;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (abort) begin
                    cancel    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    check_vec = 1'b1;
                    state_nxt = (vec == last_vec) ? DONE : DRIVE;
                end
            end
            DONE: begin
                done      = 1'b1;
                cancel    = abort;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run datapath: selection latch, vector counter, drive register, error tally, verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q    <= GATE_NOR2;
            vec       <= '0;
            dut_in    <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            if (accept_start) begin
                gate_q    <= gate_sel_t'(gate_sel);
                vec       <= '0;
                err_count <= '0;
            end
            if (drive_vec) begin
                dut_in <= (gate_q == GATE_NOR2) ? {1'b0, vec[1:0]} : vec;
            end
            if (check_vec) begin
                err_count <= err_next;
                if (vec == last_vec) begin
                    pass   <= (err_next == '0);
                    dut_in <= '0;
                end else begin
                    vec <= vec + 3'd1;
                end
            end
            if (cancel) begin
                dut_in <= '0;
            end
        end
    end

`ifdef GVS_FIRST_FAIL_LOG_EN
    // First mismatch of the run is latched and held until the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (accept_start) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (check_vec && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= dut_in;
        end
    end
`endif

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Self-checking bench for gate_vector_sequencer with a behavioural cell and reference model.
module tb_gate_vector_sequencer;

    localparam int S1 = 2;
    localparam int S2 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       gate_sel;
    logic [2:0] dut_in;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;

    logic       start2;
    logic       gate_sel2;
    logic [2:0] dut_in2;
    logic       busy2;
    logic       done2;
    logic       pass2;
    logic [1:0] err_count2;

`ifdef GVS_FIRST_FAIL_LOG_EN
    logic       first_fail_vld;
    logic [2:0] first_fail_vec;
    logic       first_fail_vld2;
    logic [2:0] first_fail_vec2;
`endif

    // cell_mode: 0 = faulty-by-mask model, 1 = stuck-at-0, 2 = stuck-at-1
    int         cell_mode;
    logic       cell_sel;
    logic [7:0] fault_mask;

    int         checks = 0;
    int         passes = 0;

    int         run_cycles;
    logic [2:0] run_vec [8];
    logic       run_busy_ok;
    logic [3:0] run_err_at_start;
    logic       run_done_after;

    gate_vector_sequencer #(.SETTLE_CYCLES(S1), .ERR_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .gate_sel (gate_sel),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count)
`ifdef GVS_FIRST_FAIL_LOG_EN
        ,
        .first_fail_vld(first_fail_vld),
        .first_fail_vec(first_fail_vec)
`endif
    );

    gate_vector_sequencer #(.SETTLE_CYCLES(S2), .ERR_W(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .abort    (1'b0),
        .gate_sel (gate_sel2),
        .dut_in   (dut_in2),
        .dut_out  (1'b0),
        .busy     (busy2),
        .done     (done2),
        .pass     (pass2),
        .err_count(err_count2)
`ifdef GVS_FIRST_FAIL_LOG_EN
        ,
        .first_fail_vld(first_fail_vld2),
        .first_fail_vec(first_fail_vec2)
`endif
    );

    always #5 clk = ~clk;

    // Truth-table reference: NOR2 is 1 only when a and b are both 0; OAI21 is 0 only when c and (a or b).
    function automatic logic ref_gate(input logic sel, input logic [2:0] v);
        if (!sel) return (v[0] == 1'b0) && (v[1] == 1'b0);
        return !(((v[0] == 1'b1) || (v[1] == 1'b1)) && (v[2] == 1'b1));
    endfunction

    function automatic logic cell_value(input int mode, input logic sel, input logic [7:0] m,
                                        input logic [2:0] v);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return ref_gate(sel, v) ^ m[v];
    endfunction

    always_comb dut_out = cell_value(cell_mode, cell_sel, fault_mask, dut_in);

    // Mismatches over the first n_vec vectors, saturated at max_cnt.
    function automatic int exp_err(input logic sel, input int n_vec, input int max_cnt);
        int n = 0;
        for (int v = 0; v < n_vec; v++) begin
            if (cell_value(cell_mode, sel, fault_mask, 3'(v)) != ref_gate(sel, 3'(v))) n++;
        end
        return (n > max_cnt) ? max_cnt : n;
    endfunction

    function automatic int exp_first(input logic sel, input int n_vec);
        for (int v = 0; v < n_vec; v++) begin
            if (cell_value(cell_mode, sel, fault_mask, 3'(v)) != ref_gate(sel, 3'(v))) return v;
        end
        return -1;
    endfunction

    // Starts a run, follows it to done, then steps into the following IDLE cycle.
    task automatic do_run(input logic sel, input int disturb_at);
        int k;
        gate_sel = sel;
        start    = 1'b1;
        for (int i = 0; i < 8; i++) run_vec[i] = 3'bxxx;
        @(posedge clk); #1;
        start            = 1'b0;
        run_cycles       = 0;
        run_busy_ok      = busy;
        run_err_at_start = err_count;
        while (run_cycles <= 400) begin
            if (run_cycles == disturb_at) begin
                start    = 1'b1;
                gate_sel = ~sel;
            end
            @(posedge clk); #1;
            start = 1'b0;
            run_cycles++;
            if (done) break;
            if (!busy) run_busy_ok = 1'b0;
            if (((run_cycles - 1) % (S1 + 2)) == 0) begin
                k = (run_cycles - 1) / (S1 + 2);
                if (k < 8) run_vec[k] = dut_in;
            end
        end
        gate_sel = sel;
        @(posedge clk); #1;
        run_done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; gate_sel = 1'b0;
        start2 = 1'b0; gate_sel2 = 1'b0;
        cell_mode = 0; cell_sel = 1'b0; fault_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dut_in !== 3'd0) $display("FAIL reset_dut_in: got %0d expected 0", dut_in); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (pass !== 1'b0) $display("FAIL reset_pass: got %b expected 0", pass); else passes++;
        checks++; if (err_count !== 4'd0) $display("FAIL reset_err: got %0d expected 0", err_count); else passes++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nor2_correct;
        cell_mode = 0; cell_sel = 1'b0; fault_mask = '0;
        do_run(1'b0, -1);
        checks++; if (run_cycles !== 4 * (S1 + 2)) $display("FAIL nor2_cycles: got %0d expected %0d", run_cycles, 4 * (S1 + 2)); else passes++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (run_vec[k] !== 3'(k)) $display("FAIL nor2_vec%0d: got %b expected %b", k, run_vec[k], 3'(k));
            else passes++;
        end
        checks++; if (err_count !== 4'd0) $display("FAIL nor2_err: got %0d expected 0", err_count); else passes++;
        checks++; if (pass !== 1'b1) $display("FAIL nor2_pass: got %b expected 1", pass); else passes++;
        checks++; if (run_busy_ok !== 1'b1) $display("FAIL nor2_busy: got %b expected 1", run_busy_ok); else passes++;
        checks++; if (run_done_after !== 1'b0) $display("FAIL nor2_done_width: got %b expected 0", run_done_after); else passes++;
    endtask

    task automatic test_abort;
        logic saw_done;
        int   partial;
        cell_mode = 0; cell_sel = 1'b1; fault_mask = 8'($urandom) | 8'h01;
        partial = exp_err(1'b1, 2, 15);
        gate_sel = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2 * (S1 + 2) + 1) @(posedge clk);
        #1;
        checks++; if (dut_in !== 3'd2) $display("FAIL abort_pre_vec: got %0d expected 2", dut_in); else passes++;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passes++;
        checks++; if (dut_in !== 3'd0) $display("FAIL abort_dut_in: got %0d expected 0", dut_in); else passes++;
        checks++; if (err_count !== 4'(partial)) $display("FAIL abort_err: got %0d expected %0d", err_count, partial); else passes++;
        checks++; if (pass !== 1'b1) $display("FAIL abort_pass_held: got %b expected 1", pass); else passes++;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", saw_done); else passes++;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL abort_beats_start: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_reset_midrun;
        cell_mode = 1; cell_sel = 1'b1;
        gate_sel = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (S1 + 3) @(posedge clk);
        #3;
        checks++; if (dut_in !== 3'd1) $display("FAIL rst_pre_dut_in: got %0d expected 1", dut_in); else passes++;
        checks++; if (err_count !== 4'd1) $display("FAIL rst_pre_err: got %0d expected 1", err_count); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b expected 0", busy); else passes++;
        checks++; if (dut_in !== 3'd0) $display("FAIL rst_async_dut_in: got %0d expected 0", dut_in); else passes++;
        checks++; if (err_count !== 4'd0) $display("FAIL rst_async_err: got %0d expected 0", err_count); else passes++;
        checks++; if (pass !== 1'b0) $display("FAIL rst_async_pass: got %b expected 0", pass); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stuck;
        cell_mode = 1; cell_sel = 1'b1;
        do_run(1'b1, -1);
        checks++; if (run_cycles !== 8 * (S1 + 2)) $display("FAIL s0_cycles: got %0d expected %0d", run_cycles, 8 * (S1 + 2)); else passes++;
        checks++; if (err_count !== 4'd5) $display("FAIL s0_err: got %0d expected 5", err_count); else passes++;
        checks++; if (pass !== 1'b0) $display("FAIL s0_pass: got %b expected 0", pass); else passes++;
`ifdef GVS_FIRST_FAIL_LOG_EN
        checks++; if ({first_fail_vld, first_fail_vec} !== 4'b1_000) $display("FAIL s0_first: got %b_%b expected 1_000", first_fail_vld, first_fail_vec); else passes++;
`endif
        cell_mode = 2;
        do_run(1'b1, -1);
        checks++; if (err_count !== 4'd3) $display("FAIL s1_err: got %0d expected 3", err_count); else passes++;
        checks++; if (pass !== 1'b0) $display("FAIL s1_pass: got %b expected 0", pass); else passes++;
`ifdef GVS_FIRST_FAIL_LOG_EN
        checks++; if ({first_fail_vld, first_fail_vec} !== 4'b1_101) $display("FAIL s1_first: got %b_%b expected 1_101", first_fail_vld, first_fail_vec); else passes++;
`endif
    endtask

    task automatic test_saturation;
        int cyc = 0;
        gate_sel2 = 1'b1; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        while (cyc <= 200) begin
            @(posedge clk); #1;
            cyc++;
            if (done2) break;
        end
        checks++; if (cyc !== 8 * (S2 + 2)) $display("FAIL sat_cycles: got %0d expected %0d", cyc, 8 * (S2 + 2)); else passes++;
        checks++; if (err_count2 !== 2'd3) $display("FAIL sat_err: got %0d expected 3", err_count2); else passes++;
        checks++; if (pass2 !== 1'b0) $display("FAIL sat_pass: got %b expected 0", pass2); else passes++;
    endtask

    task automatic test_start_ignored;
        int e;
        cell_mode = 0; cell_sel = 1'b0; fault_mask = 8'($urandom);
        e = exp_err(1'b0, 4, 15);
        do_run(1'b0, 6);
        checks++; if (run_cycles !== 4 * (S1 + 2)) $display("FAIL ign_cycles: got %0d expected %0d", run_cycles, 4 * (S1 + 2)); else passes++;
        checks++; if (run_vec[3] !== 3'd3) $display("FAIL ign_vec3: got %b expected 011", run_vec[3]); else passes++;
        checks++; if (err_count !== 4'(e)) $display("FAIL ign_err: got %0d expected %0d", err_count, e); else passes++;
        checks++; if (pass !== (e == 0)) $display("FAIL ign_pass: got %b expected %b", pass, (e == 0)); else passes++;
    endtask

    task automatic test_back_to_back;
        cell_mode = 1; cell_sel = 1'b1;
        do_run(1'b1, -1);
        cell_mode = 0; fault_mask = '0;
        do_run(1'b1, -1);
        checks++; if (run_err_at_start !== 4'd0) $display("FAIL b2b_err_cleared: got %0d expected 0", run_err_at_start); else passes++;
        checks++; if (run_cycles !== 8 * (S1 + 2)) $display("FAIL b2b_cycles: got %0d expected %0d", run_cycles, 8 * (S1 + 2)); else passes++;
        checks++; if (pass !== 1'b1) $display("FAIL b2b_pass: got %b expected 1", pass); else passes++;
        checks++; if (err_count !== 4'd0) $display("FAIL b2b_err: got %0d expected 0", err_count); else passes++;
    endtask

    task automatic test_random;
        logic sel;
        int   nv;
        int   e;
        int   ff;
        for (int r = 0; r < 8; r++) begin
            sel = 1'($urandom_range(0, 1));
            nv  = sel ? 8 : 4;
            cell_mode = 0; cell_sel = sel; fault_mask = 8'($urandom);
            e  = exp_err(sel, nv, 15);
            ff = exp_first(sel, nv);
            do_run(sel, -1);
            checks++; if (run_cycles !== nv * (S1 + 2)) $display("FAIL rnd%0d_cycles: got %0d expected %0d", r, run_cycles, nv * (S1 + 2)); else passes++;
            checks++; if (err_count !== 4'(e)) $display("FAIL rnd%0d_err: got %0d expected %0d", r, err_count, e); else passes++;
            checks++; if (pass !== (e == 0)) $display("FAIL rnd%0d_pass: got %b expected %b", r, pass, (e == 0)); else passes++;
            for (int k = 0; k < nv; k++) begin
                checks++;
                if (run_vec[k] !== 3'(k)) $display("FAIL rnd%0d_vec%0d: got %b expected %b", r, k, run_vec[k], 3'(k));
                else passes++;
            end
`ifdef GVS_FIRST_FAIL_LOG_EN
            checks++;
            if (first_fail_vld !== (ff >= 0) || ((ff >= 0) && (first_fail_vec !== 3'(ff))))
                $display("FAIL rnd%0d_first: got %b_%b expected index %0d", r, first_fail_vld, first_fail_vec, ff);
            else passes++;
`endif
        end
    endtask

    initial begin
        test_reset;
        test_nor2_correct;
        test_abort;
        test_reset_midrun;
        test_stuck;
        test_saturation;
        test_start_ignored;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
